// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V types and load encodings for the writeback path
package rv_pkg;

    localparam int XLEN = 32;

    // Register-file address
    typedef logic [4:0] reg_addr_t;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One pending register write
    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-entry FIFO with two pushes and one pop per cycle
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   push0_valid/push0_data   first write this cycle (lands in front of push1)
//   push1_valid/push1_data   second write this cycle
//   pop                      remove head this cycle (ignored when empty)
//   head_data                oldest entry
//   count                    number of valid entries (0..2)
//
// The caller must never push more than the slots free after the pop.
module wb_fifo #(
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_valid,
    input  logic [WIDTH-1:0] push0_data,
    input  logic             push1_valid,
    input  logic [WIDTH-1:0] push1_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] q      [2];
    logic [WIDTH-1:0] q_next [2];
    logic [1:0]       cnt_next;

    // Entries are kept head-aligned: slot 0 is always the oldest, so a pop
    // is a shift and a push lands at index = current occupancy.
    always_comb begin
        q_next   = q;
        cnt_next = count;
        if (pop && count != 2'd0) begin
            q_next[0] = q[1];
            cnt_next  = count - 2'd1;
        end
        if (push0_valid) begin
            q_next[cnt_next[0]] = push0_data;
            cnt_next            = cnt_next + 2'd1;
        end
        if (push1_valid) begin
            q_next[cnt_next[0]] = push1_data;
            cnt_next            = cnt_next + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q[0]  <= '0;
            q[1]  <= '0;
            count <= 2'd0;
        end else begin
            q     <= q_next;
            count <= cnt_next;
        end
    end

    assign head_data = q[0];

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - register writeback: ALU/load merge, load extension, busy scoreboard
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   issue_valid/issue_rd/issue_ready   decode claims a destination register
//   alu_valid/alu_rd/alu_data/alu_ready ALU result source
//   ld_valid/ld_rd/ld_funct3/ld_addr_lo/ld_rdata/ld_ready  load data source
//   rf_we/rf_waddr/rf_wdata            registered register-file write port
//   busy                               per-register pending-write scoreboard
module reg_writeback
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  reg_addr_t       issue_rd,
    output logic            issue_ready,
    input  logic            alu_valid,
    input  reg_addr_t       alu_rd,
    input  logic [31:0]     alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  reg_addr_t       ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [31:0]     ld_rdata,
    output logic            ld_ready,
    output logic            rf_we,
    output reg_addr_t       rf_waddr,
    output logic [31:0]     rf_wdata,
    output logic [31:0]     busy
);

    // Select and extend the addressed byte/halfword of a raw memory word.
    function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   extend_load = {{24{b[7]}}, b};
            F3_LH:   extend_load = {{16{h[15]}}, h};
            F3_LBU:  extend_load = {24'h0, b};
            F3_LHU:  extend_load = {16'h0, h};
            default: extend_load = word;
        endcase
    endfunction

    wb_entry_t  head;
    wb_entry_t  ld_entry;
    wb_entry_t  alu_entry;
    wb_entry_t  push0_data;
    logic [1:0] fifo_count;
    logic [1:0] free_slots;
    logic       pop;
    logic       ld_fire;
    logic       alu_fire;
    logic       issue_fire;
    logic [31:0] busy_next;

    // Reset suppresses the pop, so a full FIFO reports no free slot while
    // reset is high; transfers in that cycle are discarded anyway.
    assign pop        = !reset && (fifo_count != 2'd0);
    assign free_slots = 2'd2 - fifo_count + {1'b0, pop};

    // Loads take the first free slot; the ALU needs a second one when a
    // load is also offered. Neither ready depends on alu_valid.
    assign ld_ready  = (free_slots != 2'd0);
    assign alu_ready = ld_valid ? (free_slots == 2'd2) : (free_slots != 2'd0);

    assign ld_fire  = ld_valid  && ld_ready;
    assign alu_fire = alu_valid && alu_ready;

    assign ld_entry  = '{rd: ld_rd,  data: extend_load(ld_funct3, ld_addr_lo, ld_rdata)};
    assign alu_entry = '{rd: alu_rd, data: alu_data};

    // Load goes ahead of the ALU result when both transfer together.
    assign push0_data = ld_fire ? ld_entry : alu_entry;

    wb_fifo #(
        .WIDTH (WB_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push0_valid (ld_fire || alu_fire),
        .push0_data  (push0_data),
        .push1_valid (ld_fire && alu_fire),
        .push1_data  (alu_entry),
        .pop         (pop),
        .head_data   (head),
        .count       (fifo_count)
    );

    // Write port: one cycle after pop. Entries for x0 are popped silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= pop && (head.rd != '0);
            if (pop && head.rd != '0) begin
                rf_waddr <= head.rd;
                rf_wdata <= head.data;
            end
        end
    end

    // Scoreboard
    assign issue_ready = !busy[issue_rd];
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

    // Clear follows the write by one cycle; a same-cycle set overrides it.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule
